// File: rtl/status_flag_if.sv
// Flag-unit bus: EXE-stage flag sources in, {N,Z,C,V} status and shadow out.
// The master drives the sources; the slave (status_flag_unit) drives the status.
interface status_flag_if;
    logic        s_en;
    logic        freeze;
    logic [1:0]  op_class;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        carry_out;
    logic        shift_carry;
    logic        wr_en;
    logic [3:0]  wr_data;
    logic        save;
    logic        restore;
    logic [3:0]  sr;
    logic [3:0]  sr_next;
    logic        sr_upd;
    logic [3:0]  shadow;

    modport master (
        output s_en, freeze, op_class, a, b, result, carry_out, shift_carry,
        output wr_en, wr_data, save, restore,
        input  sr, sr_next, sr_upd, shadow
    );

    modport slave (
        input  s_en, freeze, op_class, a, b, result, carry_out, shift_carry,
        input  wr_en, wr_data, save, restore,
        output sr, sr_next, sr_upd, shadow
    );
endinterface

// File: rtl/status_flag_unit.sv
// Status register {N,Z,C,V} with ALU flag generation, direct write and forwarding.
// Define STATUS_SHADOW_EN to enable the save/restore shadow copy of the flags.
module status_flag_unit (
    input  logic         clk,
    input  logic         rst,
    status_flag_if.slave bus
);

    localparam logic [1:0] OP_LOGIC = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_NZ    = 2'b11;

    // Flags produced by the EXE-stage instruction; cur supplies retained C/V.
    function automatic logic [3:0] gen_flags(
        input logic [1:0] op,
        input logic       a31,
        input logic       b31,
        input logic       r31,
        input logic       r_zero,
        input logic       co,
        input logic       sc,
        input logic [3:0] cur
    );
        logic c_s;
        logic v_s;
        c_s = cur[1];
        v_s = cur[0];
        case (op)
            OP_LOGIC: begin
                c_s = sc;
                v_s = cur[0];
            end
            OP_ADD: begin
                c_s = co;
                v_s = (a31 == b31) && (r31 != a31);
            end
            OP_SUB: begin
                c_s = co;
                v_s = (a31 != b31) && (r31 != a31);
            end
            OP_NZ: begin
                c_s = cur[1];
                v_s = cur[0];
            end
            default: begin
                c_s = cur[1];
                v_s = cur[0];
            end
        endcase
        return {r31, r_zero, c_s, v_s};
    endfunction

    logic [3:0] sr_q;
    logic [3:0] sr_d;
    logic       upd_q;
    logic       upd_d;
    logic [3:0] shadow_q;
    logic [3:0] shadow_d;
    logic       save_act_s;
    logic       restore_act_s;
    logic [3:0] alu_flags_s;
    logic       unused_opnd_s;

    assign unused_opnd_s = ^{bus.a[30:0], bus.b[30:0]};

    assign alu_flags_s = gen_flags(bus.op_class, bus.a[31], bus.b[31], bus.result[31],
                                   (bus.result == 32'h0000_0000), bus.carry_out,
                                   bus.shift_carry, sr_q);

`ifdef STATUS_SHADOW_EN
    assign save_act_s    = bus.save;
    assign restore_act_s = bus.restore;

    // Shadow copy register
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= 4'b0000;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    logic [3:0] unused_shadow_s;
    logic       unused_strobe_s;

    assign save_act_s      = 1'b0;
    assign restore_act_s   = 1'b0;
    assign shadow_q        = 4'b0000;
    assign unused_shadow_s = shadow_d;
    assign unused_strobe_s = bus.save ^ bus.restore;
`endif

    // Next-state selection: rst > freeze > restore > wr_en > s_en > hold
    always_comb begin
        sr_d     = sr_q;
        shadow_d = shadow_q;
        upd_d    = 1'b0;
        if (rst) begin
            sr_d     = 4'b0000;
            shadow_d = 4'b0000;
            upd_d    = 1'b0;
        end else if (bus.freeze) begin
            sr_d     = sr_q;
            shadow_d = shadow_q;
            upd_d    = 1'b0;
        end else begin
            // Shadow captures sr as it was before this edge, so save+restore swaps.
            if (save_act_s) begin
                shadow_d = sr_q;
            end else begin
                shadow_d = shadow_q;
            end
            if (restore_act_s) begin
                sr_d  = shadow_q;
                upd_d = 1'b1;
            end else if (bus.wr_en) begin
                sr_d  = bus.wr_data;
                upd_d = 1'b1;
            end else if (bus.s_en) begin
                sr_d  = alu_flags_s;
                upd_d = 1'b1;
            end else begin
                sr_d  = sr_q;
                upd_d = 1'b0;
            end
        end
    end

    // Status register and update pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= 4'b0000;
            upd_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            upd_q <= upd_d;
        end
    end

    assign bus.sr      = sr_q;
    assign bus.sr_next = sr_d;
    assign bus.sr_upd  = upd_q;
    assign bus.shadow  = shadow_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed-vector bench for status_flag_unit with a queue-based scoreboard.
module tb_status_flag_unit;

    logic clk;
    logic rst;

    status_flag_if bus ();

    status_flag_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         id;
        logic [3:0] sr;
        logic       upd;
        logic [3:0] shadow;
    } exp_t;

    exp_t       sb_q[$];
    int         n_vec  = 0;
    int         n_cmp  = 0;
    int         n_miss = 0;
    logic [3:0] next_snap;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sr_next snapshot just before the active edge, after inputs have settled
    always @(negedge clk) begin
        #4;
        next_snap = bus.sr_next;
    end

    task automatic check4(input string name, input int id, input logic [3:0] act, input logic [3:0] req);
        n_cmp++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s vec %0d: got %b, expected %b", name, id, act, req);
        end
    endtask

    // Monitor: one expected record per edge, checked just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check4("sr", e.id, bus.sr, e.sr);
                check4("sr_upd", e.id, {3'b000, bus.sr_upd}, {3'b000, e.upd});
                check4("shadow", e.id, bus.shadow, e.shadow);
                check4("sr_next", e.id, next_snap, e.sr);
            end
        end
    end

    task automatic vec(
        input logic        r,
        input logic        fz,
        input logic        se,
        input logic [1:0]  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] res,
        input logic        co,
        input logic        sc,
        input logic        we,
        input logic [3:0]  wd,
        input logic        sv,
        input logic        rs,
        input logic [3:0]  e_sr,
        input logic        e_upd,
        input logic [3:0]  e_sh
    );
        exp_t e;
        @(negedge clk);
        rst             = r;
        bus.freeze      = fz;
        bus.s_en        = se;
        bus.op_class    = op;
        bus.a           = a;
        bus.b           = b;
        bus.result      = res;
        bus.carry_out   = co;
        bus.shift_carry = sc;
        bus.wr_en       = we;
        bus.wr_data     = wd;
        bus.save        = sv;
        bus.restore     = rs;
        e.id     = n_vec;
        e.sr     = e_sr;
        e.upd    = e_upd;
        e.shadow = e_sh;
        sb_q.push_back(e);
        n_vec++;
    endtask

    task automatic idle(input logic [3:0] e_sr, input logic [3:0] e_sh);
        vec(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0,
            1'b0, 4'b0000, 1'b0, 1'b0, e_sr, 1'b0, e_sh);
    endtask

    initial begin
        int budget;
        rst             = 1'b0;
        bus.freeze      = 1'b0;
        bus.s_en        = 1'b0;
        bus.op_class    = 2'b00;
        bus.a           = 32'h0;
        bus.b           = 32'h0;
        bus.result      = 32'h0;
        bus.carry_out   = 1'b0;
        bus.shift_carry = 1'b0;
        bus.wr_en       = 1'b0;
        bus.wr_data     = 4'b0000;
        bus.save        = 1'b0;
        bus.restore     = 1'b0;

        //  rst  frz  s_en  op     a             b             result        co    sc    wr    wd       sav   rst   -> sr  upd  shadow
        vec(1'b1,1'b0,1'b1,2'b01,32'h7FFF_FFFF,32'h0000_0001,32'h8000_0000,1'b0,1'b1,1'b1,4'b1111,1'b0,1'b0, 4'b0000,1'b0,4'b0000);
        idle(4'b0000, 4'b0000);
        // add overflow
        vec(1'b0,1'b0,1'b1,2'b01,32'h7FFF_FFFF,32'h0000_0001,32'h8000_0000,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0, 4'b1001,1'b1,4'b0000);
        // sub equal -> zero, no borrow; then hold
        vec(1'b0,1'b0,1'b1,2'b10,32'h0000_0005,32'h0000_0005,32'h0000_0000,1'b1,1'b0,1'b0,4'b0000,1'b0,1'b0, 4'b0110,1'b1,4'b0000);
        idle(4'b0110, 4'b0000);
        // logic op keeps V
        vec(1'b0,1'b0,1'b0,2'b00,32'h0,32'h0,32'h0,1'b0,1'b0,1'b1,4'b0001,1'b0,1'b0, 4'b0001,1'b1,4'b0000);
        vec(1'b0,1'b0,1'b1,2'b00,32'h0,32'h0,32'h0000_0000,1'b0,1'b1,1'b0,4'b0000,1'b0,1'b0, 4'b0111,1'b1,4'b0000);
        // NZ-only: C,V retained despite carry inputs
        vec(1'b0,1'b0,1'b1,2'b11,32'h8000_0000,32'h8000_0000,32'hFFFF_0000,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0, 4'b1011,1'b1,4'b0000);
        // sub signed overflow
        vec(1'b0,1'b0,1'b1,2'b10,32'h8000_0000,32'h0000_0001,32'h7FFF_FFFF,1'b1,1'b0,1'b0,4'b0000,1'b0,1'b0, 4'b0011,1'b1,4'b0000);
        // add unsigned carry, no overflow
        vec(1'b0,1'b0,1'b1,2'b01,32'hFFFF_FFFF,32'h0000_0001,32'h0000_0000,1'b1,1'b0,1'b0,4'b0000,1'b0,1'b0, 4'b0110,1'b1,4'b0000);
        // wr_en beats s_en; then same under freeze
        vec(1'b0,1'b0,1'b1,2'b01,32'h7FFF_FFFF,32'h0000_0001,32'h8000_0000,1'b0,1'b0,1'b1,4'b1010,1'b0,1'b0, 4'b1010,1'b1,4'b0000);
        vec(1'b0,1'b1,1'b1,2'b01,32'h7FFF_FFFF,32'h0000_0001,32'h8000_0000,1'b0,1'b0,1'b1,4'b1010,1'b0,1'b0, 4'b1010,1'b0,4'b0000);
        vec(1'b0,1'b1,1'b1,2'b10,32'h0000_0005,32'h0000_0005,32'h0000_0000,1'b1,1'b0,1'b0,4'b0000,1'b0,1'b0, 4'b1010,1'b0,4'b0000);
        vec(1'b0,1'b0,1'b0,2'b00,32'h0,32'h0,32'h0,1'b0,1'b0,1'b1,4'b1100,1'b0,1'b0, 4'b1100,1'b1,4'b0000);
`ifdef STATUS_SHADOW_EN
        vec(1'b0,1'b0,1'b0,2'b00,32'h0,32'h0,32'h0,1'b0,1'b0,1'b0,4'b0000,1'b1,1'b0, 4'b1100,1'b0,4'b1100);
        vec(1'b0,1'b0,1'b0,2'b00,32'h0,32'h0,32'h0,1'b0,1'b0,1'b1,4'b0011,1'b0,1'b0, 4'b0011,1'b1,4'b1100);
        vec(1'b0,1'b0,1'b0,2'b00,32'h0,32'h0,32'h0,1'b0,1'b0,1'b0,4'b0000,1'b1,1'b1, 4'b1100,1'b1,4'b0011);
        vec(1'b0,1'b0,1'b0,2'b00,32'h0,32'h0,32'h0,1'b0,1'b0,1'b1,4'b0101,1'b0,1'b1, 4'b0011,1'b1,4'b0011);
        vec(1'b0,1'b1,1'b0,2'b00,32'h0,32'h0,32'h0,1'b0,1'b0,1'b0,4'b0000,1'b1,1'b1, 4'b0011,1'b0,4'b0011);
`else
        vec(1'b0,1'b0,1'b0,2'b00,32'h0,32'h0,32'h0,1'b0,1'b0,1'b0,4'b0000,1'b1,1'b0, 4'b1100,1'b0,4'b0000);
        vec(1'b0,1'b0,1'b0,2'b00,32'h0,32'h0,32'h0,1'b0,1'b0,1'b1,4'b0011,1'b0,1'b0, 4'b0011,1'b1,4'b0000);
        vec(1'b0,1'b0,1'b0,2'b00,32'h0,32'h0,32'h0,1'b0,1'b0,1'b0,4'b0000,1'b1,1'b1, 4'b0011,1'b0,4'b0000);
        vec(1'b0,1'b0,1'b0,2'b00,32'h0,32'h0,32'h0,1'b0,1'b0,1'b1,4'b0101,1'b0,1'b1, 4'b0101,1'b1,4'b0000);
        vec(1'b0,1'b1,1'b0,2'b00,32'h0,32'h0,32'h0,1'b0,1'b0,1'b0,4'b0000,1'b1,1'b1, 4'b0101,1'b0,4'b0000);
`endif
        vec(1'b0,1'b0,1'b0,2'b00,32'h0,32'h0,32'h0,1'b0,1'b0,1'b1,4'b1111,1'b1,1'b0, 4'b1111,1'b1,
`ifdef STATUS_SHADOW_EN
            4'b0011);
`else
            4'b0000);
`endif
        // reset wins over freeze and a pending write
        vec(1'b1,1'b1,1'b1,2'b01,32'h7FFF_FFFF,32'h0000_0001,32'h8000_0000,1'b0,1'b0,1'b1,4'b0101,1'b1,1'b1, 4'b0000,1'b0,4'b0000);
        idle(4'b0000, 4'b0000);
        vec(1'b0,1'b0,1'b1,2'b01,32'h7FFF_FFFF,32'h0000_0001,32'h8000_0000,1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0, 4'b1001,1'b1,4'b0000);

        @(negedge clk);
        bus.s_en  = 1'b0;
        bus.wr_en = 1'b0;
        budget = 0;
        while (sb_q.size() != 0 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (sb_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d records left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/status_flag_unit.md
STATUS_FLAG_UNIT -- requirements
Module: status_flag_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port s_en, input, 1 bit: EXE-stage instruction has its S bit set and passed the condition check; requests a flag update.
REQ-004 SHALL have port freeze, input, 1 bit: pipeline stall; all state held.
REQ-005 SHALL have port op_class, input, 2 bits: 00 logic/move, 01 add/adc, 10 sub/sbc/cmp, 11 NZ-only.
REQ-006 SHALL have ports a and b, input, 32 bits each: ALU operands.
REQ-007 SHALL have port result, input, 32 bits: ALU result.
REQ-008 SHALL have port carry_out, input, 1 bit: adder bit 32 (for subtraction, 1 means no borrow).
REQ-009 SHALL have port shift_carry, input, 1 bit: barrel-shifter carry out.
REQ-010 SHALL have port wr_en, input, 1 bit: direct flag write (MSR-style).
REQ-011 SHALL have port wr_data, input, 4 bits: {N,Z,C,V} value for the direct write.
REQ-012 SHALL have ports save and restore, input, 1 bit each: exception entry and return strobes.
REQ-013 SHALL have port sr, output, 4 bits: registered {N,Z,C,V}, in the bit order the condition checker consumes.
REQ-014 SHALL have port sr_next, output, 4 bits: combinational value sr takes at the next edge, used for forwarding.
REQ-015 SHALL have port sr_upd, output, 1 bit: registered pulse, high for the one cycle after an update is applied.
REQ-016 SHALL have port shadow, output, 4 bits: saved flags.

Function
REQ-017 The generated N flag SHALL equal result[31], and Z SHALL be 1 when result equals 0.
REQ-018 For op_class 00, C SHALL take the value of shift_carry, and V SHALL be unchanged.
REQ-019 For op_class 01, C SHALL take carry_out, and V SHALL be (a[31]==b[31]) AND (result[31]!=a[31]).
REQ-020 For op_class 10, C SHALL take carry_out, and V SHALL be (a[31]!=b[31]) AND (result[31]!=a[31]).
REQ-021 For op_class 11, N and Z SHALL update while C and V are unchanged.
REQ-022 The update priority per edge SHALL be: rst > freeze > restore > wr_en > s_en > hold.
REQ-023 When wr_en is asserted, sr SHALL take wr_data; a simultaneous s_en is discarded.
REQ-024 sr_next SHALL always equal the value sr holds after the next edge; it equals sr when freeze is asserted or no source is active.
REQ-025 sr_upd SHALL be 1 in the cycle after restore, wr_en or s_en was applied (not frozen), even if the value did not change; otherwise it is 0.
REQ-026 The flag update latency SHALL be one cycle: flags from the instruction in cycle k are visible on sr in cycle k+1.
REQ-027 There SHALL be no internal state beyond sr, shadow and sr_upd.

Reset
REQ-028 When rst is 1 at a clock edge, sr SHALL become 0000, shadow SHALL become 0000 and sr_upd SHALL become 0, regardless of all other inputs including freeze.
REQ-029 Reset asserted in the middle of a stall SHALL clear state in that same edge; on release, behaviour SHALL resume normally with no pending update.

Configuration
REQ-030 The macro STATUS_SHADOW_EN SHALL control the shadow feature.
REQ-031 With STATUS_SHADOW_EN defined:
- save (when not frozen) SHALL load shadow with the current sr, taken before any update in the same edge.
- restore SHALL load sr with shadow.
- save and restore in the same cycle SHALL swap sr and shadow.
REQ-032 Without STATUS_SHADOW_EN:
- save and restore SHALL be ignored.
- shadow SHALL be tied to 0000.
- sr_upd SHALL never be caused by restore.

Verification
REQ-033 The bench SHALL cover: add with a=0x7FFFFFFF, b=1, result=0x80000000, carry_out=0, s_en=1 -> next cycle sr=1001 and sr_upd=1.
REQ-034 The bench SHALL cover: sub with a=5, b=5, result=0, carry_out=1, s_en=1 -> sr=0110; a following cycle with s_en=0 keeps sr=0110 and gives sr_upd=0.
REQ-035 The bench SHALL cover: logic op with sr=0001, result=0x00000000, shift_carry=1, s_en=1 -> sr=0111 (V retained).
REQ-036 The bench SHALL cover: wr_en=1, wr_data=1010 together with s_en=1 -> sr=1010; the same stimulus with freeze=1 -> sr unchanged, sr_upd=0, and sr_next=sr.
REQ-037 The bench SHALL cover, with STATUS_SHADOW_EN defined: sr=1100, save=1 -> shadow=1100; then wr_data=0011 -> sr=0011; then save=1 with restore=1 -> sr=1100 and shadow=0011.
REQ-038 The bench SHALL cover: rst=1 together with freeze=1 while sr=1111 -> sr=0000, shadow=0000 and sr_upd=0 after one edge.
